// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the shared-ALU controller.
//   - 3-bit ALU opcode encodings
//   - controller FSM state encodings
package alu_pkg;

    localparam logic [2:0] OP_NOT  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_ADD  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_ZERO = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational DATA_W-bit ALU; all results are taken
// modulo 2^DATA_W.
//   i_op  opcode (alu_pkg OP_*)
//   i_a   operand A
//   i_b   operand B
//   o_y   result
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_y
);

    always_comb begin
        o_y = '0;
        case (i_op)
            OP_NOT:  o_y = ~i_a;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_AND:  o_y = i_a & i_b;
            // DATA_W-wide context keeps only the low half of the product
            OP_MUL:  o_y = i_a * i_b;
            OP_ADD:  o_y = i_a + i_b;
            OP_SUB:  o_y = i_a - i_b;
            OP_ZERO: o_y = '0;
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one alu_core between two requesters.
// Round-robin grant, one transaction in flight, registered result held
// under response backpressure, wrapping completed-operation counter.
//   clk, rst_n                      clock, async active-low reset
//   rN_valid/rN_ready               command handshake, requester N
//   rN_opcode, rN_a, rN_b           command payload, requester N
//   rsp_valid/rsp_ready             result handshake
//   rsp_data, rsp_id, rsp_zero      result, issuing requester, result==0
//   op_count                        completed transactions (wraps)
//
// state | meaning
// IDLE  | waiting for a command; ready offered to the granted requester
// EXEC  | ALU evaluates latched operands; result registered at cycle end
// RESP  | result presented until rsp_ready; then pointer flips, back to IDLE
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [2:0]        r0_opcode,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [2:0]        r1_opcode,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              rsp_zero,
    output logic [CNT_W-1:0]  op_count
);

    logic [1:0]        r_state;
    logic              r_prio;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              r_id;
    logic [DATA_W-1:0] r_data;
    logic              r_zero;
    logic [CNT_W-1:0]  r_count;

    logic              w_idle;
    logic              w_gnt_id;
    logic              w_req_hs;
    logic [DATA_W-1:0] w_alu;

    assign w_idle   = (r_state == ST_IDLE);
    // Contention goes to the pointer; otherwise whichever one is valid.
    assign w_gnt_id = (r0_valid && r1_valid) ? r_prio : r1_valid;
    assign r0_ready = w_idle && r0_valid && !w_gnt_id;
    assign r1_ready = w_idle && r1_valid && w_gnt_id;
    assign w_req_hs = r0_ready || r1_ready;

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .i_op (r_op),
        .i_a  (r_a),
        .i_b  (r_b),
        .o_y  (w_alu)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_id    <= 1'b0;
            r_data  <= '0;
            r_zero  <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_hs) begin
                        r_op    <= w_gnt_id ? r1_opcode : r0_opcode;
                        r_a     <= w_gnt_id ? r1_a : r0_a;
                        r_b     <= w_gnt_id ? r1_b : r0_b;
                        r_id    <= w_gnt_id;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_data  <= w_alu;
                    r_zero  <= (w_alu == '0);
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_count <= r_count + CNT_W'(1);
                        r_prio  <= ~r_id;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_data  = r_data;
    assign rsp_id    = r_id;
    assign rsp_zero  = r_zero;
    assign op_count  = r_count;

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              r0_valid, r1_valid;
    logic              r0_ready, r1_ready;
    logic [2:0]        r0_opcode, r1_opcode;
    logic [DATA_W-1:0] r0_a, r0_b, r1_a, r1_b;
    logic              rsp_valid, rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_id, rsp_zero;
    logic [CNT_W-1:0]  op_count;

    alu_share_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_opcode (r0_opcode),
        .r0_a      (r0_a),
        .r0_b      (r0_b),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_opcode (r1_opcode),
        .r1_a      (r1_a),
        .r1_b      (r1_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_zero  (rsp_zero),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        logic [8:0]  s;
        p = {8'h00, a} * {8'h00, b};
        s = {1'b0, a} + {1'b0, b};
        case (op)
            3'd0: return ~a;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return a & b;
            3'd4: return p[7:0];
            3'd5: return s[7:0];
            3'd6: return 8'((9'h100 + {1'b0, a} - {1'b0, b}) & 9'h0FF);
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- scoreboard / monitor ----------------
    typedef struct {
        logic       id;
        logic [7:0] data;
    } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    always @(posedge clk) cyc++;

    int hs_cyc = 0;
    int exp_cnt = 0;
    bit pend_cnt = 0;
    bit busy = 0;
    bit prev_v = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = 0;
            pend_cnt = 0;
            busy = 0;
            prev_v = 0;
        end else begin
            if (pend_cnt) begin
                chk("op_count", 32'(op_count), 32'(exp_cnt));
                pend_cnt = 0;
            end
            if (r0_ready || r1_ready) begin
                exp_t e;
                chk("ready_only_idle", 32'(busy), 0);
                chk("ready_one_hot", 32'(r0_ready & r1_ready), 0);
                chk("ready_needs_valid", 32'((r0_ready & ~r0_valid) | (r1_ready & ~r1_valid)), 0);
                e.id   = r1_ready;
                e.data = r1_ready ? model_alu(r1_opcode, r1_a, r1_b) : model_alu(r0_opcode, r0_a, r0_b);
                exp_q.push_back(e);
                busy = 1;
                hs_cyc = cyc;
            end
            if (rsp_valid && !prev_v) chk("latency", 32'(cyc - hs_cyc), 2);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_data", 32'(rsp_data), 32'(e.data));
                    chk("sb_id", 32'(rsp_id), 32'(e.id));
                    chk("sb_zero", 32'(rsp_zero), 32'(e.data == 8'h00));
                end
                exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
                pend_cnt = 1;
                busy = 0;
            end
            prev_v = rsp_valid;
        end
    end

    // ---------------- helpers ----------------
    task automatic drive_req(input bit id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        if (id) begin
            r1_valid = 1'b1; r1_opcode = op; r1_a = a; r1_b = b;
        end else begin
            r0_valid = 1'b1; r0_opcode = op; r0_a = a; r0_b = b;
        end
    endtask

    // Waits for the grant, lets the handshake edge pass, then drops valid.
    task automatic wait_ready(input bit id);
        bit got;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id ? r1_ready : r0_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) chk(id ? "timeout_r1_ready" : "timeout_r0_ready", 0, 1);
        @(posedge clk);
        #1;
        if (id) r1_valid = 1'b0; else r0_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [7:0] d, output logic id, output logic z);
        bit got;
        got = 0;
        d = '0; id = 1'b0; z = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1;
                d = rsp_data; id = rsp_id; z = rsp_zero;
                break;
            end
        end
        if (!got) chk("timeout_rsp", 0, 1);
    endtask

    typedef struct {
        bit         id;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[12];

    logic [7:0] d;
    logic       rid, rz;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{0, 3'd4, 8'h0F, 8'h03, 8'h2D};
        vecs[1]  = '{1, 3'd5, 8'hC8, 8'h64, 8'h2C};
        vecs[2]  = '{1, 3'd6, 8'h03, 8'h05, 8'hFE};
        vecs[3]  = '{1, 3'd7, 8'hAA, 8'h55, 8'h00};
        vecs[4]  = '{0, 3'd0, 8'h5A, 8'h00, 8'hA5};
        vecs[5]  = '{0, 3'd1, 8'hF0, 8'h0F, 8'hFF};
        vecs[6]  = '{1, 3'd2, 8'hFF, 8'h0F, 8'hF0};
        vecs[7]  = '{0, 3'd3, 8'h3C, 8'hF0, 8'h30};
        vecs[8]  = '{1, 3'd4, 8'hFF, 8'hFF, 8'h01};
        vecs[9]  = '{0, 3'd5, 8'hFF, 8'h01, 8'h00};
        vecs[10] = '{1, 3'd6, 8'h00, 8'h01, 8'hFF};
        vecs[11] = '{0, 3'd0, 8'hFF, 8'h00, 8'h00};

        rst_n = 1'b0;
        r0_valid = 0; r1_valid = 0; rsp_ready = 1'b1;
        r0_opcode = 0; r0_a = 0; r0_b = 0;
        r1_opcode = 0; r1_a = 0; r1_b = 0;
        #23;
        chk("rst_r0_ready", 32'(r0_ready), 0);
        chk("rst_r1_ready", 32'(r1_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_rsp_id", 32'(rsp_id), 0);
        chk("rst_rsp_zero", 32'(rsp_zero), 0);
        chk("rst_op_count", 32'(op_count), 0);
        @(posedge clk); #2 rst_n = 1'b1;

        // both valid continuously after reset: grants alternate from r0
        @(posedge clk); #1;
        drive_req(0, 3'd5, 8'h01, 8'h02);
        drive_req(1, 3'd6, 8'h09, 8'h04);
        for (int k = 0; k < 4; k++) begin
            wait_rsp(d, rid, rz);
            chk("alt_id", 32'(rid), 32'(k % 2));
            chk("alt_data", 32'(d), (k % 2) ? 32'h05 : 32'h03);
            @(posedge clk); #1;
        end
        r0_valid = 0; r1_valid = 0;

        // table-driven single-requester vectors
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            drive_req(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
            wait_ready(vecs[i].id);
            wait_rsp(d, rid, rz);
            chk("vec_data", 32'(d), 32'(vecs[i].exp));
            chk("vec_id", 32'(rid), 32'(vecs[i].id));
            chk("vec_zero", 32'(rz), 32'(vecs[i].exp == 8'h00));
            @(posedge clk); #1;
        end

        // backpressure with r1 pending during RESP
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        drive_req(0, 3'd1, 8'h12, 8'h21);
        wait_ready(0);
        drive_req(1, 3'd2, 8'h0F, 8'hFF);
        wait_rsp(d, rid, rz);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_data", 32'(rsp_data), 32'h33);
            chk("bp_id", 32'(rsp_id), 0);
            chk("bp_no_r1_ready", 32'(r1_ready), 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_ready(1);
        wait_rsp(d, rid, rz);
        chk("bp_next_data", 32'(d), 32'hF0);
        chk("bp_next_id", 32'(rid), 1);
        @(posedge clk); #1;

        // r0 served -> pointer at r1; then reset during r1's EXEC
        drive_req(0, 3'd5, 8'h01, 8'h01);
        wait_ready(0);
        wait_rsp(d, rid, rz);
        @(posedge clk); #1;
        drive_req(1, 3'd3, 8'hFF, 8'h0F);
        wait_ready(1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rsp_valid", 32'(rsp_valid), 0);
        chk("arst_rsp_data", 32'(rsp_data), 0);
        chk("arst_rsp_id", 32'(rsp_id), 0);
        chk("arst_rsp_zero", 32'(rsp_zero), 0);
        chk("arst_op_count", 32'(op_count), 0);
        chk("arst_r1_ready", 32'(r1_ready), 0);
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("arst_no_rsp", 32'(rsp_valid), 0);
        end
        @(posedge clk); #1;
        drive_req(0, 3'd0, 8'h00, 8'h00);
        drive_req(1, 3'd1, 8'h11, 8'h22);
        @(negedge clk);
        chk("arst_r0_wins", 32'(r0_ready), 1);
        chk("arst_r1_waits", 32'(r1_ready), 0);
        @(posedge clk); #1;
        r0_valid = 0; r1_valid = 0;
        wait_rsp(d, rid, rz);
        chk("arst_first_data", 32'(d), 32'hFF);
        chk("arst_first_id", 32'(rid), 0);
        @(posedge clk); #1;

        // counter wrap: fresh reset, 16 transactions back to zero
        rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            drive_req(k[0], 3'(k % 8), 8'(k * 7), 8'(k + 3));
            wait_ready(k[0]);
            wait_rsp(d, rid, rz);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("wrap_op_count", 32'(op_count), 0);
        chk("sb_drained", 32'(exp_q.size()), 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
